// File: rtl/spi_frame_pkg.sv
// Shared constants, command codes and state encoding for the SPI frame writer.
package spi_frame_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] CMD_WRITE_FRAME = 8'hA5;
  localparam logic [DATA_W-1:0] CMD_WRITE_AT    = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_DROP
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer for an asynchronous pin, plus one history flop for edge detection.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Idle-high so a released reset never looks like a chip-select fall or clock edge.
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_frame_writer.sv
// SPI mode-0 slave that turns a command/address/data byte stream into frame-buffer BRAM writes.
module spi_frame_writer
  import spi_frame_pkg::*;
#(
  parameter int FRAME_BYTES = 32768,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int                LIMIT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [LIMIT_W-1:0] FRAME_LIMIT = LIMIT_W'(FRAME_BYTES);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .rst_n(rst_n), .din(spi_sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_level, sck_fall, mosi_rise, mosi_fall};

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt;
  logic [DATA_W-1:0]   shift_q;
  logic [6:0]          addr_hi_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic                drop_quiet;

  logic                accept, byte_valid;
  logic [DATA_W-1:0]   byte_data;
  logic                do_write, load_frame, load_hi, load_lo, set_ovr, cmd_bad;

  // An sck edge landing with the cs_n rise still belongs to the closing byte.
  assign accept     = sck_rise & (~cs_level | cs_rise) & ~cs_fall;
  assign byte_valid = accept & (bit_cnt == 3'd7);
  assign byte_data  = {shift_q[DATA_W-2:0], mosi_level};
  assign busy       = ~cs_level;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    do_write   = 1'b0;
    load_frame = 1'b0;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    set_ovr    = 1'b0;
    cmd_bad    = 1'b0;
    if (byte_valid) begin
      case (state_q)
        ST_CMD: begin
          if (byte_data == CMD_WRITE_FRAME) begin
            load_frame = 1'b1;
            state_d    = ST_DATA;
          end else if (byte_data == CMD_WRITE_AT) begin
            state_d = ST_ADDR_HI;
          end else begin
            cmd_bad = 1'b1;
            state_d = ST_DROP;
          end
        end
        ST_ADDR_HI: begin
          load_hi = 1'b1;
          state_d = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          load_lo = 1'b1;
          if ({1'b0, addr_hi_q, byte_data} >= FRAME_LIMIT) begin
            set_ovr = 1'b1;
            state_d = ST_DROP;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          do_write = 1'b1;
          if (waddr_q == LAST_ADDR) state_d = ST_DROP;
        end
        ST_DROP: set_ovr = ~drop_quiet;
        default: ;
      endcase
    end
    if (cs_fall)      state_d = ST_CMD;
    else if (cs_rise) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      addr_hi_q  <= '0;
      waddr_q    <= '0;
      drop_quiet <= 1'b0;
      bram_we    <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (cs_fall | cs_rise) bit_cnt <= '0;
      else if (accept)       bit_cnt <= bit_cnt + 3'd1;

      if (accept) shift_q <= byte_data;
      if (load_hi) addr_hi_q <= byte_data[6:0];

      bram_we    <= do_write;
      frame_done <= do_write && (waddr_q == LAST_ADDR);
      if (do_write) begin
        bram_waddr <= waddr_q;
        bram_wdata <= byte_data;
        waddr_q    <= (waddr_q == LAST_ADDR) ? '0 : waddr_q + ADDR_W'(1);
      end else if (load_frame) begin
        waddr_q <= '0;
      end else if (load_lo) begin
        waddr_q <= {addr_hi_q, byte_data};
      end

      if (cs_fall)      drop_quiet <= 1'b0;
      else if (cmd_bad) drop_quiet <= 1'b1;

      if (cs_fall)      overrun <= 1'b0;
      else if (set_ovr) overrun <= 1'b1;
    end
  end

endmodule
